// File: rtl/shift_seq_ctrl.sv
// Iterative shift sequencer: shifts a 32-bit operand by up to STEP bits per clock.
// Optional abort input enabled by defining SHIFT_SEQ_KILL_EN.
module shift_seq_ctrl #(
  parameter int STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  input  logic [1:0]  type_i,
`ifdef SHIFT_SEQ_KILL_EN
  input  logic        kill_i,
`endif
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] r_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;
  localparam logic [4:0] STEP_C  = 5'(STEP);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] r_q, r_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        kill_s;
  logic [4:0]  step_s;
  logic [4:0]  cnt_rem_s;
  logic [31:0] shifted_s;

`ifdef SHIFT_SEQ_KILL_EN
  assign kill_s = kill_i;
`else
  assign kill_s = 1'b0;
`endif

  // One iteration of the datapath: s = min(STEP, cnt), so cnt can never underflow.
  always_comb begin
    step_s    = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    cnt_rem_s = cnt_q - step_s;
    case (op_q)
      OP_SRL:  shifted_s = acc_q >> step_s;
      OP_SLL:  shifted_s = acc_q << step_s;
      OP_SRA:  shifted_s = 32'($signed(acc_q) >>> step_s);
      default: shifted_s = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !kill_s) begin
          acc_d = a_i;
          cnt_d = shamt_i;
          op_d  = type_i;
          if ((type_i == OP_PASS) || (shamt_i == 5'd0)) begin
            state_d = S_DONE;
            r_d     = a_i;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (kill_s) begin
          state_d = S_IDLE;
        end else begin
          acc_d = shifted_s;
          cnt_d = cnt_rem_s;
          if (cnt_rem_s == 5'd0) begin
            state_d = S_DONE;
            r_d     = shifted_s;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      // DONE lasts one cycle regardless of kill, so the pulse is never repeated.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, datapath and output flags; reset overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= 5'd0;
      op_q    <= 2'b00;
      r_q     <= 32'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign r_o     = r_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: three instances (STEP 1, 4, 16) share one stimulus.
// Kill scenario is included only when SHIFT_SEQ_KILL_EN is defined.
module tb_shift_seq_ctrl;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  typ;
    logic [31:0] exp_r;
  } vec_t;

  localparam int STEPS [3] = '{1, 4, 16};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [1:0]  typ = 2'b00;
  logic        kill = 1'b0;
  logic        ready_w [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [31:0] r_w     [3];

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [11];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .shamt_i(shamt), .type_i(typ),
`ifdef SHIFT_SEQ_KILL_EN
    .kill_i(kill),
`endif
    .ready_o(ready_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .r_o(r_w[0])
  );

  shift_seq_ctrl #(.STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .shamt_i(shamt), .type_i(typ),
`ifdef SHIFT_SEQ_KILL_EN
    .kill_i(kill),
`endif
    .ready_o(ready_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .r_o(r_w[1])
  );

  shift_seq_ctrl #(.STEP(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .shamt_i(shamt), .type_i(typ),
`ifdef SHIFT_SEQ_KILL_EN
    .kill_i(kill),
`endif
    .ready_o(ready_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .r_o(r_w[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v, input int step);
    if (v.typ == 2'b11 || v.shamt == 5'd0) return 0;
    return (int'(v.shamt) + step - 1) / step;
  endfunction

  // Issue one op to all instances and check latency, result, single done pulse, busy length.
  task automatic run_op(input vec_t v, input string tag);
    int first [3];
    int nd [3];
    logic [31:0] rd [3];
    int nbusy;
    nbusy = 0;
    for (int d = 0; d < 3; d++) begin
      first[d] = -1;
      nd[d] = 0;
      rd[d] = 32'd0;
    end
    @(negedge clk);
    a = v.a; shamt = v.shamt; typ = v.typ; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; shamt = 5'd3; typ = 2'b01;
    for (int j = 0; j <= 40; j++) begin
      for (int d = 0; d < 3; d++) begin
        if (done_w[d]) begin
          if (first[d] < 0) begin
            first[d] = j;
            rd[d] = r_w[d];
          end
          nd[d]++;
        end
      end
      if (busy_w[0]) nbusy++;
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s lat step%0d", tag, STEPS[d]), 32'(first[d]), 32'(exp_lat(v, STEPS[d])));
      chk($sformatf("%s r step%0d", tag, STEPS[d]), rd[d], v.exp_r);
      chk($sformatf("%s ndone step%0d", tag, STEPS[d]), 32'(nd[d]), 32'd1);
    end
    chk($sformatf("%s busy_cycles", tag), 32'(nbusy), 32'(exp_lat(v, 1) + 1));
    chk($sformatf("%s ready_after", tag), 32'(ready_w[0]), 32'd1);
  endtask

  initial begin
    int first;
    logic [31:0] rfirst;
    logic [31:0] prior_r;

    vecs[0]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
    vecs[1]  = '{32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000};
    vecs[2]  = '{32'hF000_000F, 5'd0,  2'b00, 32'hF000_000F};
    vecs[3]  = '{32'h1234_5678, 5'd17, 2'b11, 32'h1234_5678};
    vecs[4]  = '{32'hFFFF_0000, 5'd8,  2'b00, 32'h00FF_FF00};
    vecs[5]  = '{32'h1234_5678, 5'd5,  2'b00, 32'h0091_A2B3};
    vecs[6]  = '{32'h8765_4321, 5'd3,  2'b10, 32'hF0EC_A864};
    vecs[7]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    vecs[8]  = '{32'hA5A5_A5A5, 5'd4,  2'b01, 32'h5A5A_5A50};
    vecs[9]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vecs[10] = '{32'hFFFF_FFFF, 5'd17, 2'b01, 32'hFFFE_0000};

    repeat (3) @(negedge clk);
    chk("reset ready", 32'(ready_w[0]), 32'd1);
    chk("reset busy",  32'(busy_w[0]),  32'd0);
    chk("reset done",  32'(done_w[0]),  32'd0);
    chk("reset r",     r_w[0],          32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed while busy must be ignored by the STEP=1 instance.
    first = -1;
    rfirst = 32'd0;
    @(negedge clk);
    a = 32'hFFFF_0000; shamt = 5'd8; typ = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= 40; j++) begin
      if (j == 2) begin
        a = 32'h0000_0001; shamt = 5'd1; typ = 2'b00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (j == 3) chk("busy_start busy", 32'(busy_w[0]), 32'd1);
      if (done_w[0] && first < 0) begin
        first = j;
        rfirst = r_w[0];
      end
      if (j == 12) chk("busy_start r_hold", r_w[0], 32'h00FF_FF00);
      @(negedge clk);
    end
    chk("busy_start lat", 32'(first), 32'd8);
    chk("busy_start r", rfirst, 32'h00FF_FF00);

    // Synchronous reset in the middle of a shamt=10 op.
    @(negedge clk);
    a = 32'hFFFF_FFFF; shamt = 5'd10; typ = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst ready", 32'(ready_w[0]), 32'd1);
    chk("midrst busy",  32'(busy_w[0]),  32'd0);
    chk("midrst done",  32'(done_w[0]),  32'd0);
    chk("midrst r",     r_w[0],          32'd0);
    chk("midrst r step4", r_w[1], 32'd0);
    first = -1;
    for (int j = 0; j < 15; j++) begin
      if (done_w[0]) first = j;
      @(negedge clk);
    end
    chk("midrst no_done", 32'(first), 32'hFFFF_FFFF);
    run_op(vecs[5], "after_rst");

`ifdef SHIFT_SEQ_KILL_EN
    // Kill three edges into a shamt=10 SRL: back to IDLE, no pulse, r untouched.
    prior_r = vecs[5].exp_r;
    @(negedge clk);
    a = 32'hFFFF_FFFF; shamt = 5'd10; typ = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill ready", 32'(ready_w[0]), 32'd1);
    chk("kill done",  32'(done_w[0]),  32'd0);
    chk("kill r",     r_w[0],          prior_r);
    first = -1;
    for (int j = 0; j < 15; j++) begin
      if (done_w[0]) first = j;
      @(negedge clk);
    end
    chk("kill no_done", 32'(first), 32'hFFFF_FFFF);
    chk("kill r_hold", r_w[0], prior_r);
    @(negedge clk);
    a = 32'h1234_5678; shamt = 5'd4; typ = 2'b00; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill blocks start", 32'(ready_w[0]), 32'd1);
    run_op(vecs[0], "after_kill");
`else
    prior_r = 32'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
